bitstream_loader: RTL and testbench

Upstream feeder for the configuration deserializer: accepts configuration words over a valid/ready handshake and serializes them, MSB-first, into a single-bit stream with a per-bit valid strobe. It emits exactly CFG_SIZE valid bits per load, so the downstream deserializer's bit count lands on CFG_SIZE. It reports busy/done status to the configuration controller.

---
 rtl/bitstream_loader_if.sv | 24 ++
 rtl/bitstream_loader.sv | 99 +++++++++
 tb/tb_bitstream_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bitstream_loader_if.sv
// bitstream_loader_if: word handshake, serial stream and status bundle for bitstream_loader
// master: configuration controller / word source (drives Start, WordIn, WordValid)
// slave: bitstream_loader (drives WordReady, SerialOut, StreamValidOut, Busy, LoadDone, CrcErr)
interface bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic Start;
  logic [WORD_W-1:0] WordIn;
  logic WordValid;
  logic WordReady;
  logic SerialOut;
  logic StreamValidOut;
  logic Busy;
  logic LoadDone;
  logic CrcErr;
  modport master (
    output Start, WordIn, WordValid,
    input WordReady, SerialOut, StreamValidOut, Busy, LoadDone, CrcErr
  );
  modport slave (
    input Start, WordIn, WordValid,
    output WordReady, SerialOut, StreamValidOut, Busy, LoadDone, CrcErr
  );
endinterface

// File: rtl/bitstream_loader.sv
// bitstream_loader: serializes configuration words MSB-first into exactly CFG_SIZE valid stream bits
// Ports: clk; rst (asynchronous, active-high); b (bitstream_loader_if.slave): Start, WordIn,
//   WordValid in; WordReady (decoded from state), SerialOut, StreamValidOut, Busy, LoadDone,
//   CrcErr out (registered).
// Option: define BITSTREAM_LOADER_CRC_EN to follow the stream with a CRC-8 (poly 0x07) check word.
module bitstream_loader #(
  parameter int CFG_SIZE = 100,
  parameter int WORD_W = 32
) (
  input logic clk,
  input logic rst,
  bitstream_loader_if.slave b
);
  localparam int BW = $clog2(CFG_SIZE + 1);
  localparam int CW = $clog2(WORD_W + 1);
`ifdef BITSTREAM_LOADER_CRC_EN
  typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT, CRC_WORD, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;
`endif
  state_t state, nxt;
  logic [WORD_W-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic signed [31:0] rem;
  logic start_acc, word_hs, last_bit;
  logic so_n, svo_n, busy_n, done_n;
  assign start_acc = (state == IDLE || state == DONE) && b.Start;
  assign word_hs = state == WAIT_WORD && b.WordValid;
  assign last_bit = state == SHIFT && cnt == CW'(1);
  assign rem = CFG_SIZE - int'(bits);
`ifdef BITSTREAM_LOADER_CRC_EN
  logic [7:0] crc, crc_n;
  logic err_n, crc_hs;
  assign crc_hs = state == CRC_WORD && b.WordValid;
  assign b.WordReady = state == WAIT_WORD || state == CRC_WORD;
`else
  assign b.WordReady = state == WAIT_WORD;
  assign b.CrcErr = 1'b0;
`endif
  // rem == 1 on the last word bit means this bit completes the load
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = b.Start ? WAIT_WORD : state;
      WAIT_WORD: nxt = b.WordValid ? SHIFT : WAIT_WORD;
`ifdef BITSTREAM_LOADER_CRC_EN
      SHIFT: nxt = !last_bit ? SHIFT : rem == 1 ? CRC_WORD : WAIT_WORD;
      CRC_WORD: nxt = b.WordValid ? DONE : CRC_WORD;
`else
      SHIFT: nxt = !last_bit ? SHIFT : rem == 1 ? DONE : WAIT_WORD;
`endif
      default: nxt = IDLE;
    endcase
  end
  // Outputs are computed for the next state so every stream/status output comes from a flop
  always_comb begin
    sr_n = word_hs ? b.WordIn : state == SHIFT ? sr << 1 : sr;
    cnt_n = word_hs ? CW'(rem < WORD_W ? rem : WORD_W) : state == SHIFT ? cnt - CW'(1) : cnt;
    bits_n = start_acc ? '0 : state == SHIFT ? bits + BW'(1) : bits;
    so_n = nxt == SHIFT && sr_n[WORD_W-1];
    svo_n = nxt == SHIFT;
    busy_n = nxt != IDLE && nxt != DONE;
    done_n = nxt == DONE;
`ifdef BITSTREAM_LOADER_CRC_EN
    crc_n = start_acc ? 8'h00 : state == SHIFT ?
            {crc[6:0], 1'b0} ^ ((crc[7] ^ sr[WORD_W-1]) ? 8'h07 : 8'h00) : crc;
    err_n = start_acc ? 1'b0 : crc_hs ? b.WordIn[7:0] != crc : b.CrcErr;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bits <= '0;
      b.SerialOut <= 1'b0;
      b.StreamValidOut <= 1'b0;
      b.Busy <= 1'b0;
      b.LoadDone <= 1'b0;
`ifdef BITSTREAM_LOADER_CRC_EN
      crc <= 8'h00;
      b.CrcErr <= 1'b0;
`endif
    end else begin
      state <= nxt;
      sr <= sr_n;
      cnt <= cnt_n;
      bits <= bits_n;
      b.SerialOut <= so_n;
      b.StreamValidOut <= svo_n;
      b.Busy <= busy_n;
      b.LoadDone <= done_n;
`ifdef BITSTREAM_LOADER_CRC_EN
      crc <= crc_n;
      b.CrcErr <= err_n;
`endif
    end
endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: randomized self-checking bench for bitstream_loader (CFG_SIZE 100 and 64)
module tb_bitstream_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
`ifdef BITSTREAM_LOADER_CRC_EN
  localparam int LAT100 = 106;
  localparam int LAT64 = 68;
`else
  localparam int LAT100 = 105;
  localparam int LAT64 = 67;
`endif
  localparam logic [99:0] FIXED = 100'hDEADBEEF0123456789ABCDEFA;
  bitstream_loader_if #(.WORD_W(32)) bi ();
  bitstream_loader_if #(.WORD_W(32)) bi64 ();
  bitstream_loader #(.CFG_SIZE(100), .WORD_W(32)) dut (.clk(clk), .rst(rst), .b(bi));
  bitstream_loader #(.CFG_SIZE(64), .WORD_W(32)) dut64 (.clk(clk), .rst(rst), .b(bi64));
  bit sel;
  logic start_d, valid_d;
  logic [31:0] word_d;
  assign bi.Start = sel ? 1'b0 : start_d;
  assign bi64.Start = sel ? start_d : 1'b0;
  assign bi.WordValid = sel ? 1'b0 : valid_d;
  assign bi64.WordValid = sel ? valid_d : 1'b0;
  assign bi.WordIn = word_d;
  assign bi64.WordIn = word_d;
  logic ready_s, so_s, svo_s, busy_s, done_s, err_s;
  assign ready_s = sel ? bi64.WordReady : bi.WordReady;
  assign so_s = sel ? bi64.SerialOut : bi.SerialOut;
  assign svo_s = sel ? bi64.StreamValidOut : bi.StreamValidOut;
  assign busy_s = sel ? bi64.Busy : bi.Busy;
  assign done_s = sel ? bi64.LoadDone : bi.LoadDone;
  assign err_s = sel ? bi64.CrcErr : bi.CrcErr;
  int vectors, miscompares;
  bit exp_bits [0:127];
  int exp_len, load_id, seen_id, idx;
  logic [99:0] cap;
  bit pend_done;
  logic [31:0] words [0:4];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Stream checker: every valid bit is matched against the expected bit sequence of the current load
  always @(negedge clk) begin
    if (load_id != seen_id) begin
      seen_id = load_id;
      idx = 0;
      cap = '0;
    end
    if (!rst) begin
`ifndef BITSTREAM_LOADER_CRC_EN
      if (pend_done) begin
        chk("done_after_last_bit", 128'(done_s), 128'(1));
        chk("busy_after_last_bit", 128'(busy_s), 128'(0));
      end
      chk("crc_err_tied_low", 128'(err_s), 128'(0));
`endif
      pend_done = 1'b0;
      if (svo_s) begin
        chk("busy_while_streaming", 128'(busy_s), 128'(1));
        if (idx >= exp_len) chk("extra_bit", 128'(svo_s), 128'(0));
        else begin
          chk("stream_bit", 128'(so_s), 128'(exp_bits[idx]));
          cap = {cap[98:0], so_s};
          idx++;
          pend_done = idx == exp_len;
        end
      end else chk("serial_zero_when_idle", 128'(so_s), 128'(0));
    end
  end
  task automatic run_load(input int abort_at, input int stall_at, input bit gaps, input bit noise,
                          input bit flip, input int exp_lat);
    int cfg = sel ? 64 : 100;
    int nw = (cfg + 31) / 32;
    int wi = 0;
    int lat = 1;
    int stall_left = 10;
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 0; i < cfg; i++) begin
      exp_bits[i] = words[i / 32][31 - i % 32];
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ exp_bits[i]) ? 8'h07 : 8'h00);
    end
    exp_len = cfg;
    load_id++;
`ifdef BITSTREAM_LOADER_CRC_EN
    words[nw] = {24'h0, crc ^ {7'h0, flip}};
    nw++;
`endif
    @(negedge clk);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    chk("busy_after_start", 128'(busy_s), 128'(1));
    chk("ready_after_start", 128'(ready_s), 128'(1));
    chk("done_cleared_by_start", 128'(done_s), 128'(0));
    while (wi < nw && lat < 3000) begin
      if (abort_at > 0 && idx >= abort_at) begin
        start_d = 1'b0;
        valid_d = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_serial", 128'(so_s), 128'(0));
        chk("rst_valid", 128'(svo_s), 128'(0));
        chk("rst_busy", 128'(busy_s), 128'(0));
        chk("rst_done", 128'(done_s), 128'(0));
        chk("rst_ready", 128'(ready_s), 128'(0));
        chk("rst_crc_err", 128'(err_s), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("idle_after_rst_ready", 128'(ready_s), 128'(0));
        chk("idle_after_rst_busy", 128'(busy_s), 128'(0));
        return;
      end
      if (wi == stall_at && stall_left > 0 && ready_s) begin
        valid_d = 1'b0;
        stall_left--;
        chk("quiet_during_stall", 128'(svo_s), 128'(0));
      end else valid_d = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      word_d = valid_d ? words[wi] : 32'($urandom);
      start_d = noise && !ready_s && ($urandom_range(0, 3) == 0);
      if (ready_s && valid_d) wi++;
      @(negedge clk);
      lat++;
    end
    start_d = 1'b0;
    valid_d = noise;
    word_d = 32'($urandom);
    while (!done_s && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("load_done", 128'(done_s), 128'(1));
    chk("busy_at_done", 128'(busy_s), 128'(0));
    chk("bit_count", 128'(idx), 128'(cfg));
    chk("crc_err", 128'(err_s), 128'(flip));
    if (exp_lat > 0) chk("latency", 128'(lat), 128'(exp_lat));
    repeat (3) @(negedge clk);
    chk("done_held", 128'(done_s), 128'(1));
    valid_d = 1'b0;
  endtask
  initial begin
    bit flip;
    vectors = 0;
    miscompares = 0;
    sel = 1'b0;
    start_d = 1'b0;
    valid_d = 1'b0;
    word_d = '0;
    load_id = 0;
    seen_id = 0;
    exp_len = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(ready_s), 128'(0));
    chk("reset_serial", 128'(so_s), 128'(0));
    chk("reset_valid", 128'(svo_s), 128'(0));
    chk("reset_busy", 128'(busy_s), 128'(0));
    chk("reset_done", 128'(done_s), 128'(0));
    chk("reset_crc_err", 128'(err_s), 128'(0));
    rst = 1'b0;
    words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hA0000000, 32'h0};
    run_load(0, -1, 1'b0, 1'b0, 1'b0, LAT100);
    chk("capture_zero_wait", 128'(cap), 128'(FIXED));
    chk("first_four_bits", 128'(cap[99:96]), 128'(4'b1101));
    chk("last_four_bits", 128'(cap[3:0]), 128'(4'b1010));
    run_load(0, 2, 1'b0, 1'b0, 1'b0, 0);
    chk("capture_stall", 128'(cap), 128'(FIXED));
    run_load(0, -1, 1'b0, 1'b1, 1'b0, LAT100);
    chk("capture_ignored_start", 128'(cap), 128'(FIXED));
    run_load(40, -1, 1'b0, 1'b0, 1'b0, 0);
    run_load(0, -1, 1'b0, 1'b0, 1'b0, LAT100);
    chk("capture_after_reset", 128'(cap), 128'(FIXED));
`ifdef BITSTREAM_LOADER_CRC_EN
    run_load(0, -1, 1'b0, 1'b0, 1'b1, 0);
    chk("capture_bad_crc", 128'(cap), 128'(FIXED));
`endif
    sel = 1'b1;
    run_load(0, -1, 1'b0, 1'b0, 1'b0, LAT64);
    chk("capture_64", 128'(cap[63:0]), 128'(64'hDEADBEEF01234567));
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 4; k++) words[k] = $urandom;
`ifdef BITSTREAM_LOADER_CRC_EN
      flip = $urandom_range(0, 1) == 1;
`else
      flip = 1'b0;
`endif
      run_load(0, $urandom_range(0, 4) - 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               flip, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
